// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: one outstanding read on port A, in-order prefetch FIFO toward decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] address_a,
    output logic        read_a,
    input  logic        resp_a,
    input  logic [31:0] rdata_a,
    output logic        instr_valid,
    output logic [31:0] instr_rdata,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // bit 0 is the request-outstanding flag, bit 1 marks a response that must be dropped
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      fetch_pc_next_s;
    logic [31:0]      fifo_pc_r   [DEPTH];
    logic [31:0]      fifo_data_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             req_s;
    logic             push_s;
    logic             pop_s;
    logic             discard_s;

    assign req_s       = state_r[0];
    assign read_a      = req_s & ~resp_a;
    assign address_a   = {fetch_pc_r[31:2], 2'b00};
    assign instr_valid = (count_r != {CNT_W{1'b0}});
    assign instr_pc    = fifo_pc_r[rd_ptr_r];
    assign instr_rdata = fifo_data_r[rd_ptr_r];
    assign pop_s       = instr_valid & instr_ready & ~redirect_valid;

    // Request state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next request state plus push/discard decode; a redirect turns any response into a discard
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        discard_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    state_next_s = ST_IDLE;
                end else if (count_r < DEPTH_C) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (resp_a) begin
                    state_next_s = ST_IDLE;
                    if (redirect_valid) begin
                        discard_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (resp_a) begin
                    state_next_s = ST_IDLE;
                    discard_s    = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Fetch address: redirect wins, otherwise advance one word per accepted response
    always_comb begin
        if (redirect_valid) begin
            fetch_pc_next_s = {redirect_pc[31:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // Fetch address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= {RESET_PC[31:2], 2'b00};
        end else begin
            fetch_pc_r <= fetch_pc_next_s;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue and drops a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only observed through count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
            fifo_data_r[wr_ptr_r] <= rdata_a;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_discard_r;
    logic        unused_s;

    assign unused_s         = ^redirect_pc[1:0];
    assign perf_fetch_cnt   = perf_fetch_r;
    assign perf_discard_cnt = perf_discard_r;

    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_r   <= 32'h0;
            perf_discard_r <= 32'h0;
        end else begin
            if (push_s) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end
            if (discard_s) begin
                perf_discard_r <= perf_discard_r + 32'd1;
            end
        end
    end
`else
    logic unused_s;

    assign unused_s         = ^{redirect_pc[1:0], discard_s};
    assign perf_fetch_cnt   = 32'h0;
    assign perf_discard_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a small variable-latency instruction memory.
module tb_fetch_prefetch_queue;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address_a;
    logic        read_a;
    logic        resp_a;
    logic [31:0] rdata_a;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;

    logic        mem_en = 1'b1;
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        resp_mem = 1'b0;
    logic [31:0] rdata_mem = 32'h0;
    logic        resp_inj = 1'b0;
    logic [31:0] inj_data = 32'h0;
    int          resp_total = 0;
    int          overlap_cnt = 0;

    int n_assert = 0;
    int n_fail = 0;
    int snap;
    int overlap_seen;

    assign resp_a  = resp_mem | resp_inj;
    assign rdata_a = resp_inj ? inj_data : rdata_mem;

    fetch_prefetch_queue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .address_a        (address_a),
        .read_a           (read_a),
        .resp_a           (resp_a),
        .rdata_a          (rdata_a),
        .instr_valid      (instr_valid),
        .instr_rdata      (instr_rdata),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_discard_cnt (perf_discard_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h4000_0060: mem_word = 32'h0000_0013;
            32'h4000_0064: mem_word = 32'h0010_0093;
            default:       mem_word = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // memory: samples read_a on the edge, answers mem_lat cycles later, one request at a time
    always @(posedge clk) begin
        if (mem_busy) begin
            if (mem_cnt == 1) begin
                resp_mem   <= 1'b1;
                rdata_mem  <= mem_word(mem_addr);
                mem_busy   <= 1'b0;
                resp_total <= resp_total + 1;
            end else begin
                resp_mem <= 1'b0;
                mem_cnt  <= mem_cnt - 1;
            end
        end else if (mem_en && read_a) begin
            if (mem_lat == 1) begin
                resp_mem   <= 1'b1;
                rdata_mem  <= mem_word(address_a);
                resp_total <= resp_total + 1;
            end else begin
                resp_mem <= 1'b0;
                mem_busy <= 1'b1;
                mem_cnt  <= mem_lat - 1;
                mem_addr <= address_a;
            end
        end else begin
            resp_mem <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (read_a && resp_a) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_a", {31'h0, read_a}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_addr", address_a, 32'h4000_0060);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("rst_perf_discard", perf_discard_cnt, 32'h0);

        // first fetches after reset release
        rst_n = 1'b1;
        #1;
        chk("c0_read_a", {31'h0, read_a}, 32'h0);
        step();
        chk("c1_read_a", {31'h0, read_a}, 32'h1);
        chk("c1_addr", address_a, 32'h4000_0060);
        step();
        step();
        chk("c3_valid", {31'h0, instr_valid}, 32'h1);
        chk("c3_pc", instr_pc, 32'h4000_0060);
        chk("c3_data", instr_rdata, 32'h0000_0013);
        instr_ready = 1'b1;
        step();
        chk("c4_valid", {31'h0, instr_valid}, 32'h0);
        chk("c4_read_a", {31'h0, read_a}, 32'h1);
        chk("c4_addr", address_a, 32'h4000_0064);
        step();
        step();
        chk("c6_pc", instr_pc, 32'h4000_0064);
        chk("c6_data", instr_rdata, 32'h0010_0093);

        // fill with decode stalled
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0060;
        step();
        redirect_valid = 1'b0;
        snap = resp_total;
        repeat (20) step();
        chk("full_resp_count", resp_total - snap, 32'd4);
        chk("full_valid", {31'h0, instr_valid}, 32'h1);
        chk("full_pc", instr_pc, 32'h4000_0060);
        overlap_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (read_a) overlap_seen++;
            step();
        end
        chk("full_no_read", overlap_seen, 32'd0);
        instr_ready = 1'b1;
        chk("pop0_pc", instr_pc, 32'h4000_0060);
        chk("pop0_data", instr_rdata, 32'h0000_0013);
        step();
        chk("pop1_pc", instr_pc, 32'h4000_0064);
        chk("pop1_data", instr_rdata, 32'h0010_0093);
        step();
        chk("pop2_pc", instr_pc, 32'h4000_0068);
        chk("pop2_data", instr_rdata, 32'h1A5A_5A32);
        chk("resume_read_a", {31'h0, read_a}, 32'h1);
        chk("resume_addr", address_a, 32'h4000_0070);
        step();
        chk("pop3_pc", instr_pc, 32'h4000_006C);
        chk("pop3_data", instr_rdata, 32'h1A5A_5A36);
        step();
        chk("resume_valid", {31'h0, instr_valid}, 32'h1);
        chk("resume_pc", instr_pc, 32'h4000_0070);
        chk("resume_data", instr_rdata, 32'h1A5A_5A2A);

        // redirect while a response is pending
        instr_ready = 1'b0;
        mem_lat     = 3;
        step();
        chk("rd_read_a", {31'h0, read_a}, 32'h1);
        chk("rd_addr_old", address_a, 32'h4000_0074);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0103;
        step();
        redirect_valid = 1'b0;
        mem_lat        = 1;
        chk("rd_flush_valid", {31'h0, instr_valid}, 32'h0);
        chk("rd_addr_new", address_a, 32'h4000_0100);
        step();
        step();
        chk("rd_drop_valid", {31'h0, instr_valid}, 32'h0);
        chk("rd_discard_cnt", perf_discard_cnt, PERF_ON ? 32'd1 : 32'd0);
        step();
        chk("rd_refetch_read", {31'h0, read_a}, 32'h1);
        chk("rd_refetch_addr", address_a, 32'h4000_0100);
        step();
        step();
        chk("rd_new_valid", {31'h0, instr_valid}, 32'h1);
        chk("rd_new_pc", instr_pc, 32'h4000_0100);
        chk("rd_new_data", instr_rdata, 32'h1A5A_5B5A);
        chk("rd_fetch_cnt", perf_fetch_cnt, PERF_ON ? 32'd8 : 32'd0);

        // redirect together with a response and a pop
        step();
        chk("rr_addr", address_a, 32'h4000_0104);
        step();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0200;
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("rr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rr_read_a", {31'h0, read_a}, 32'h0);
        chk("rr_discard_cnt", perf_discard_cnt, PERF_ON ? 32'd2 : 32'd0);
        chk("rr_fetch_cnt", perf_fetch_cnt, PERF_ON ? 32'd8 : 32'd0);
        step();
        chk("rr_next_read", {31'h0, read_a}, 32'h1);
        chk("rr_next_addr", address_a, 32'h4000_0200);
        step();
        step();
        chk("rr_new_pc", instr_pc, 32'h4000_0200);
        chk("rr_new_data", instr_rdata, 32'h1A5A_585A);

        // address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (20) step();
        instr_ready = 1'b1;
        chk("wrap0_pc", instr_pc, 32'hFFFF_FFF8);
        chk("wrap0_data", instr_rdata, 32'hA5A5_A5A2);
        step();
        chk("wrap1_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap1_data", instr_rdata, 32'hA5A5_A5A6);
        step();
        chk("wrap2_pc", instr_pc, 32'h0000_0000);
        chk("wrap2_data", instr_rdata, 32'h5A5A_5A5A);
        instr_ready = 1'b0;
        repeat (12) step();
        chk("wrap_fetch_cnt", perf_fetch_cnt, PERF_ON ? 32'd15 : 32'd0);

        // reset in the middle of a request, stray responses around release
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0300;
        mem_en         = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mr_read_a", {31'h0, read_a}, 32'h1);
        chk("mr_addr", address_a, 32'h4000_0300);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_read_a", {31'h0, read_a}, 32'h0);
        chk("mr_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mr_rst_addr", address_a, 32'h4000_0060);
        chk("mr_rst_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("mr_rst_perf_discard", perf_discard_cnt, 32'h0);
        resp_inj = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_rel_valid", {31'h0, instr_valid}, 32'h0);
        chk("mr_rel_read_a", {31'h0, read_a}, 32'h0);
        step();
        resp_inj = 1'b0;
        mem_en   = 1'b1;
        #1;
        chk("mr_stray_valid", {31'h0, instr_valid}, 32'h0);
        chk("mr_first_read", {31'h0, read_a}, 32'h1);
        chk("mr_first_addr", address_a, 32'h4000_0060);
        chk("mr_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("mr_perf_discard", perf_discard_cnt, 32'h0);
        step();
        step();
        chk("mr_word_pc", instr_pc, 32'h4000_0060);
        chk("mr_word_data", instr_rdata, 32'h0000_0013);

        chk("read_resp_overlap", overlap_cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
